// File: rtl/video_meas_pkg.sv
// rtl/video_meas_pkg.sv - shared widths, limits and result record for the video timing meter
// Contents: H_W/V_W counter widths, PAL_LINES threshold, WDOG_CNT line timeout,
//           vid_timing_t bundle of the four reported measurements.
package video_meas_pkg;

   localparam int H_W       = 12;
   localparam int V_W       = 11;
   localparam int PAL_LINES = 288;
   localparam int WDOG_CNT  = 4096;

   typedef struct packed {
      logic [H_W-1:0] h_total;
      logic [H_W-1:0] h_active;
      logic [V_W-1:0] v_total;
      logic [V_W-1:0] v_active;
   } vid_timing_t;

endpackage

// File: rtl/video_timing_meter_if.sv
// rtl/video_timing_meter_if.sv - video input strobes and measurement results of the timing meter
// master: video source / observer (drives ce_pix, hsync, vsync, hblank, vblank; reads results)
// slave : the meter (reads video strobes; drives h_total, h_active, v_total, v_active,
//         pal_detect, locked, overflow, frame_done)
interface video_timing_meter_if;
   import video_meas_pkg::*;

   logic           ce_pix;
   logic           hsync;
   logic           vsync;
   logic           hblank;
   logic           vblank;
   logic [H_W-1:0] h_total;
   logic [H_W-1:0] h_active;
   logic [V_W-1:0] v_total;
   logic [V_W-1:0] v_active;
   logic           pal_detect;
   logic           locked;
   logic           overflow;
   logic           frame_done;

   modport master (
      output ce_pix, hsync, vsync, hblank, vblank,
      input  h_total, h_active, v_total, v_active, pal_detect, locked, overflow, frame_done
   );

   modport slave (
      input  ce_pix, hsync, vsync, hblank, vblank,
      output h_total, h_active, v_total, v_active, pal_detect, locked, overflow, frame_done
   );

endinterface

// File: rtl/sync_edge.sv
// rtl/sync_edge.sv - pixel-enable gated rising-edge detector for a sync strobe
// Ports: clk, reset (sync, active-high), ce (sample enable), din (strobe),
//        rise (combinational: din is 1 now and was 0 at the previous ce sample).
module sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic ce,
   input  logic din,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev <= 1'b0;
      end else if (ce) begin
         prev <= din;
      end
   end

   assign rise = ce & din & ~prev;

endmodule

// File: rtl/video_timing_meter.sv
// rtl/video_timing_meter.sv - measures line/field geometry of a video stream and reports lock
// Ports: clk, reset (sync, active-high), vid (slave modport): video strobes in,
//        h_total/h_active/v_total/v_active/pal_detect/locked/overflow/frame_done out.
module video_timing_meter
   import video_meas_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   video_timing_meter_if.slave   vid
);

   localparam logic [H_W-1:0] H_MAX = '1;
   localparam logic [V_W-1:0] V_MAX = '1;

   logic           h_rise;
   logic           v_rise;
   logic           active;
   logic           line_has_act;
   logic           wdog_hit;
   logic           ovf_hit;
   logic [H_W-1:0] px_cnt;
   logic [H_W-1:0] act_cnt;
   logic [H_W-1:0] line_len;
   logic [H_W-1:0] h_act_next;
   logic [V_W-1:0] ln_cnt;
   logic [V_W-1:0] vact_cnt;
   logic           armed;
   logic           hist_valid;
   logic           pal_q;
   logic           locked_q;
   logic           overflow_q;
   logic           frame_done_q;
   vid_timing_t    meas_q;
   vid_timing_t    meas_new;

   function automatic logic [H_W-1:0] inc_h(input logic [H_W-1:0] v);
      return (v == H_MAX) ? H_MAX : v + 1'b1;
   endfunction

   function automatic logic [V_W-1:0] inc_v(input logic [V_W-1:0] v);
      return (v == V_MAX) ? V_MAX : v + 1'b1;
   endfunction

   sync_edge u_hs_edge (.clk(clk), .reset(reset), .ce(vid.ce_pix), .din(vid.hsync), .rise(h_rise));
   sync_edge u_vs_edge (.clk(clk), .reset(reset), .ce(vid.ce_pix), .din(vid.vsync), .rise(v_rise));

   assign active       = ~vid.hblank & ~vid.vblank;
   assign line_has_act = (act_cnt != '0);

   // A line of WDOG_CNT samples saturates px_cnt, so the saturation value doubles as the timeout.
   assign wdog_hit = vid.ce_pix & ~h_rise & (px_cnt == H_W'(WDOG_CNT - 1));

   assign ovf_hit = vid.ce_pix & ((px_cnt == H_MAX) |
                                  (~h_rise & active & (act_cnt == H_MAX)) |
                                  (h_rise & (ln_cnt == V_MAX)) |
                                  (h_rise & line_has_act & (vact_cnt == V_MAX)));

   // Measurement set as it stands once the current sample is accounted for; an hsync rise
   // closes its line first, so a coincident vsync rise reports that line in the ending field.
   always_comb begin
      meas_new          = '0;
      meas_new.h_total  = h_rise ? inc_h(px_cnt) : line_len;
      meas_new.h_active = (h_rise && line_has_act) ? act_cnt : h_act_next;
      meas_new.v_total  = h_rise ? inc_v(ln_cnt) : ln_cnt;
      meas_new.v_active = (h_rise && line_has_act) ? inc_v(vact_cnt) : vact_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         px_cnt       <= '0;
         act_cnt      <= '0;
         line_len     <= '0;
         h_act_next   <= '0;
         ln_cnt       <= '0;
         vact_cnt     <= '0;
         armed        <= 1'b0;
         hist_valid   <= 1'b0;
         meas_q       <= '0;
         pal_q        <= 1'b0;
         locked_q     <= 1'b0;
         overflow_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         if (ovf_hit) begin
            overflow_q <= 1'b1;
         end
         if (vid.ce_pix) begin
            if (h_rise) begin
               px_cnt     <= '0;
               act_cnt    <= H_W'(active);
               line_len   <= meas_new.h_total;
               h_act_next <= meas_new.h_active;
               ln_cnt     <= meas_new.v_total;
               vact_cnt   <= meas_new.v_active;
            end else begin
               px_cnt <= inc_h(px_cnt);
               if (active) begin
                  act_cnt <= inc_h(act_cnt);
               end
            end
            if (v_rise) begin
               ln_cnt   <= '0;
               vact_cnt <= '0;
               armed    <= 1'b1;
               // The arming rise only starts a clean field; reporting begins at the next one.
               if (armed) begin
                  meas_q       <= meas_new;
                  pal_q        <= (meas_new.v_total >= V_W'(PAL_LINES));
                  locked_q     <= hist_valid && (meas_new == meas_q);
                  hist_valid   <= 1'b1;
                  frame_done_q <= 1'b1;
               end
            end
         end
         // A stalled line invalidates the comparison base, not just the current lock.
         if (wdog_hit) begin
            locked_q   <= 1'b0;
            hist_valid <= 1'b0;
         end
      end
   end

   assign vid.h_total    = meas_q.h_total;
   assign vid.h_active   = meas_q.h_active;
   assign vid.v_total    = meas_q.v_total;
   assign vid.v_active   = meas_q.v_active;
   assign vid.pal_detect = pal_q;
   assign vid.locked     = locked_q;
   assign vid.overflow   = overflow_q;
   assign vid.frame_done = frame_done_q;

endmodule

// File: tb/tb_video_timing_meter.sv
// tb/tb_video_timing_meter.sv - randomized scoreboard bench for video_timing_meter
module tb_video_timing_meter;
   import video_meas_pkg::*;

   typedef struct {
      int ht;
      int ha;
      int vt;
      int va;
      bit pal;
      bit lk;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   video_timing_meter_if vif();
   video_timing_meter dut (.clk(clk), .reset(reset), .vid(vif));

   int   checks = 0;
   int   errors = 0;
   int   fd_count = 0;
   int   fd_at;
   bit   started = 0;
   exp_t sb_q[$];

   // reference model state: plain unbounded counts, clipped only when reported
   bit m_hs_p, m_vs_p, m_armed, m_hist, m_locked, m_ovf;
   int m_since, m_act, m_last_len, m_hact, m_lines, m_alines;
   int m_pht, m_pha, m_pvt, m_pva, m_reports = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, got, exp);
      end
   endtask

   function automatic int min2(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   function automatic void model_reset();
      m_hs_p = 0; m_vs_p = 0; m_armed = 0; m_hist = 0; m_locked = 0; m_ovf = 0;
      m_since = 0; m_act = 0; m_last_len = 0; m_hact = 0; m_lines = 0; m_alines = 0;
      m_pht = 0; m_pha = 0; m_pvt = 0; m_pva = 0;
   endfunction

   function automatic void model_sample(input bit hs, input bit vs, input bit hb, input bit vb);
      bit   hr, vr, act, wd;
      exp_t e;
      hr = hs && !m_hs_p;
      vr = vs && !m_vs_p;
      act = !hb && !vb;
      m_hs_p = hs;
      m_vs_p = vs;
      m_since++;
      if (m_since >= 4096) m_ovf = 1;
      wd = !hr && (m_since >= 4096);
      if (hr) begin
         m_last_len = m_since;
         m_lines++;
         if (m_lines > 2047) m_ovf = 1;
         if (m_act > 0) begin
            m_hact = m_act;
            m_alines++;
            if (m_alines > 2047) m_ovf = 1;
         end
         m_since = 0;
         m_act = act ? 1 : 0;
      end else if (act) begin
         m_act++;
         if (m_act > 4095) m_ovf = 1;
      end
      if (vr) begin
         if (m_armed) begin
            e.ht  = min2(m_last_len, 4095);
            e.ha  = min2(m_hact, 4095);
            e.vt  = min2(m_lines, 2047);
            e.va  = min2(m_alines, 2047);
            e.pal = (e.vt > 287);
            e.lk  = m_hist && e.ht == m_pht && e.ha == m_pha && e.vt == m_pvt && e.va == m_pva;
            m_pht = e.ht; m_pha = e.ha; m_pvt = e.vt; m_pva = e.va;
            m_hist = 1;
            m_locked = e.lk;
            sb_q.push_back(e);
            m_reports++;
         end
         m_armed = 1;
         m_lines = 0;
         m_alines = 0;
      end
      if (wd) begin
         m_hist = 0;
         m_locked = 0;
      end
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         vif.ce_pix = 0; vif.hsync = 0; vif.vsync = 0; vif.hblank = 0; vif.vblank = 0;
      end
   endtask

   task automatic settle();
      idle(2);
      @(negedge clk);
   endtask

   // one ce sample, preceded by random idle cycles carrying garbage that must be ignored
   task automatic drive(input bit hs, input bit vs, input bit hb, input bit vb);
      while ($urandom_range(0, 7) == 0) begin
         @(posedge clk); #1;
         vif.ce_pix = 0;
         vif.hsync = 1'($urandom); vif.vsync = 1'($urandom);
         vif.hblank = 1'($urandom); vif.vblank = 1'($urandom);
      end
      @(posedge clk); #1;
      vif.ce_pix = 1; vif.hsync = hs; vif.vsync = vs; vif.hblank = hb; vif.vblank = vb;
      model_sample(hs, vs, hb, vb);
   endtask

   // lines l0..l1-1 of a field; hsync and vsync both rise at pixel 0 of line 0
   task automatic send_field(input int ht, input int ha, input int vt, input int va,
                             input int l0, input int l1);
      int hsw;
      int vsw;
      hsw = $urandom_range(1, ht / 2);
      vsw = $urandom_range(1, ht - 1);
      for (int l = l0; l < l1; l++)
         for (int p = 0; p < ht; p++)
            drive(p < hsw, (l == 0) && (p < vsw), p >= ha, l >= va);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1; vif.ce_pix = 0;
      model_reset();
      @(posedge clk); #1;
      reset = 0;
      @(negedge clk);
   endtask

   task automatic check_zero_outputs();
      check("rst_h_total", vif.h_total, 0);
      check("rst_h_active", vif.h_active, 0);
      check("rst_v_total", vif.v_total, 0);
      check("rst_v_active", vif.v_active, 0);
      check("rst_pal_detect", vif.pal_detect, 0);
      check("rst_locked", vif.locked, 0);
      check("rst_overflow", vif.overflow, 0);
      check("rst_frame_done", vif.frame_done, 0);
   endtask

   // monitor: pops an expectation on every frame_done, otherwise results must hold still
   logic        rst_q;
   logic [46:0] snap;
   logic [46:0] cur;
   exp_t        me;
   always @(posedge clk) rst_q <= reset;
   always @(negedge clk) begin
      cur = {vif.h_total, vif.h_active, vif.v_total, vif.v_active, vif.pal_detect};
      if (vif.frame_done === 1'b1) begin
         fd_count++;
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_done: got unexpected pulse, expected none");
         end else begin
            me = sb_q.pop_front();
            check("h_total", vif.h_total, me.ht);
            check("h_active", vif.h_active, me.ha);
            check("v_total", vif.v_total, me.vt);
            check("v_active", vif.v_active, me.va);
            check("pal_detect", vif.pal_detect, me.pal);
            check("locked", vif.locked, me.lk);
         end
      end else if (started && rst_q === 1'b0) begin
         check("hold_between_reports", cur, snap);
      end
      snap = cur;
   end

   initial begin
      reset = 1;
      vif.ce_pix = 0; vif.hsync = 0; vif.vsync = 0; vif.hblank = 0; vif.vblank = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 reset = 0;
      started = 1;
      @(negedge clk);
      check_zero_outputs();

      // NTSC-like line count, then a switch to PAL-like
      repeat (3) send_field(12, 9, 262, 240, 0, 262);
      settle();
      check("ntsc_h_total", vif.h_total, 12);
      check("ntsc_h_active", vif.h_active, 9);
      check("ntsc_v_total", vif.v_total, 262);
      check("ntsc_v_active", vif.v_active, 240);
      check("ntsc_pal", vif.pal_detect, 0);
      check("ntsc_locked", vif.locked, 1);
      repeat (2) send_field(12, 9, 312, 288, 0, 312);
      settle();
      check("pal1_v_total", vif.v_total, 312);
      check("pal1_pal", vif.pal_detect, 1);
      check("pal1_locked", vif.locked, 0);
      send_field(12, 9, 312, 288, 0, 312);
      settle();
      check("pal2_locked", vif.locked, 1);
      check("pal2_v_active", vif.v_active, 288);

      // full-width lines
      repeat (3) send_field(858, 720, 3, 2, 0, 3);
      settle();
      check("wide_h_total", vif.h_total, 858);
      check("wide_h_active", vif.h_active, 720);
      check("wide_v_total", vif.v_total, 3);
      check("wide_locked", vif.locked, 1);

      // PAL threshold boundary: 288 lines -> PAL, 287 -> not
      send_field(4, 2, 288, 200, 0, 288);
      send_field(4, 2, 287, 200, 0, 287);
      settle();
      check("b288_pal", vif.pal_detect, 1);
      send_field(4, 2, 287, 200, 0, 1);
      settle();
      check("b287_v_total", vif.v_total, 287);
      check("b287_pal", vif.pal_detect, 0);

      // lock, then stall hsync: locked must survive 4095 samples and drop at the 4096th
      repeat (3) send_field(4, 2, 20, 10, 0, 20);
      while (m_since < 4095) drive(0, 0, 1, 1);
      settle();
      check("wdog_pre_locked", vif.locked, 1);
      check("wdog_pre_overflow", vif.overflow, 0);
      drive(0, 0, 1, 1);
      settle();
      check("wdog_locked", vif.locked, 0);
      check("wdog_overflow", vif.overflow, 1);
      while (m_since < 4999) drive(0, 0, 1, 1);
      send_field(4, 2, 20, 10, 0, 20);
      settle();
      check("long_h_total", vif.h_total, 4095);
      check("long_locked", vif.locked, 0);
      repeat (2) send_field(4, 2, 20, 10, 0, 20);
      settle();
      check("relock_locked", vif.locked, 1);
      check("overflow_sticky", vif.overflow, 1);

      // reset mid-field discards the partial field; reporting resumes at the second vsync rise
      send_field(12, 9, 262, 240, 0, 100);
      settle();
      check("pending_before_reset", sb_q.size(), 0);
      do_reset();
      check_zero_outputs();
      fd_at = fd_count;
      send_field(12, 9, 262, 240, 100, 262);
      send_field(12, 9, 262, 240, 0, 262);
      settle();
      check("arm_no_frame_done", fd_count, fd_at);
      send_field(12, 9, 262, 240, 0, 262);
      settle();
      check("post_rst_frame_done", fd_count, fd_at + 1);
      check("post_rst_v_total", vif.v_total, 262);
      check("post_rst_h_total", vif.h_total, 12);
      check("post_rst_locked", vif.locked, 0);
      send_field(12, 9, 262, 240, 0, 1);
      settle();
      check("post_rst_relock", vif.locked, 1);

      settle();
      check("queue_drained", sb_q.size(), 0);
      check("frame_done_count", fd_count, m_reports);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
